// File: rtl/sr_drv_pkg.sv
// Shared types for the SR excitation driver: FSM states, 2-bit {S,R} codes
// and the per-bit excitation lookup.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RELEASE,
    CHECK
  } sr_state_e;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  // {S,R} needed to move a bit from its current value q to the target d.
  function automatic logic [1:0] sr_code(input logic q, input logic d);
    if (d && !q) return SR_SET;
    if (!d && q) return SR_RESET;
    return SR_HOLD;
  endfunction

endpackage

// File: rtl/sr_drv_encode.sv
// Combinational target/Q to S/R vector encoder; S and R are never both set
// for any bit since SR_ILLEGAL is never produced.
module sr_exc_encode
  import sr_drv_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] target_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o
);

  logic [1:0] code;

  always_comb begin
    s_o  = '0;
    r_o  = '0;
    code = SR_HOLD;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      code   = sr_code(q_i[i], target_i[i]);
      s_o[i] = (code == SR_SET);
      r_o[i] = (code == SR_RESET);
    end
  end

endmodule

// File: rtl/sr_excitation_driver.sv
// Drives S/R excitation pulses into an external SR bank and verifies the write
// via Q readback. Optional macro SR_DRV_RETRY_EN adds one retry on mismatch.
module sr_excitation_driver
  import sr_drv_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int unsigned   CW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

  sr_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] s_q, s_d, r_q, r_d;
  logic             done_q, done_d, err_q, err_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] enc_tgt, enc_s, enc_r;
`ifdef SR_DRV_RETRY_EN
  logic             retried_q, retried_d;
`endif

  // One encoder serves both the accept edge (live in_data) and the retry (held target).
  assign enc_tgt = (state_q == IDLE) ? in_data : target_q;

  sr_exc_encode #(.WIDTH(WIDTH)) u_encode (
    .target_i (enc_tgt),
    .q_i      (q_fb),
    .s_o      (enc_s),
    .r_o      (enc_r)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    s_d      = '0;
    r_d      = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    mask_d   = '0;
`ifdef SR_DRV_RETRY_EN
    retried_d = retried_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = DRIVE;
          target_d = in_data;
          s_d      = enc_s;
          r_d      = enc_r;
          cnt_d    = '0;
`ifdef SR_DRV_RETRY_EN
          retried_d = 1'b0;
`endif
        end
      end
      DRIVE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          s_d   = s_q;
          r_d   = r_q;
        end
      end
      RELEASE: state_d = CHECK;
      CHECK: begin
        if (q_fb == target_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`ifdef SR_DRV_RETRY_EN
        else if (!retried_q) begin
          state_d   = DRIVE;
          retried_d = 1'b1;
          s_d       = enc_s;
          r_d       = enc_r;
          cnt_d     = '0;
        end
`endif
        else begin
          state_d = IDLE;
          err_d   = 1'b1;
          mask_d  = q_fb ^ target_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      s_q      <= '0;
      r_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mask_q   <= '0;
`ifdef SR_DRV_RETRY_EN
      retried_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      s_q      <= s_d;
      r_q      <= r_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mask_q   <= mask_d;
`ifdef SR_DRV_RETRY_EN
      retried_q <= retried_d;
`endif
    end
  end

  assign s_out    = s_q;
  assign r_out    = r_q;
  assign done     = done_q;
  assign err      = err_q;
  assign err_mask = mask_q;
  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == IDLE);

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Scoreboard bench for sr_excitation_driver with a behavioural SR bank model.
module tb_sr_excitation_driver;

  localparam int W = 8;
  localparam int H = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] q_fb;
  logic         in_ready, busy, done, err;
  logic [W-1:0] s_out, r_out, err_mask;

  logic [W-1:0] bank  = '0;
  logic [W-1:0] stuck = '0;
  int           cyc   = 0;

  sr_excitation_driver #(.WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .q_fb     (q_fb),
    .s_out    (s_out),
    .r_out    (r_out),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_mask (err_mask)
  );

  always #5 clk = ~clk;

  assign q_fb = bank;
  always @(posedge clk) begin
    bank <= ((bank & ~r_out) | s_out) & ~stuck;
    cyc  <= cyc + 1;
  end

  typedef struct {
    int           cyc;
    bit           is_err;
    logic [W-1:0] mask;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] exp_s[int];
  logic [W-1:0] exp_r[int];
  int           idle_from = 0;
  bit           armed = 1'b0;
  int           checks = 0;
  int           errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
    end
  endtask

  // Expected behaviour from the bank's point of view: excitation pulses, the
  // value the bank settles to, and when the verdict must appear.
  task automatic predict(input int e, input logic [W-1:0] d, input logic [W-1:0] b,
                         input logic [W-1:0] st);
    exp_t         x;
    logic [W-1:0] fin;
    for (int i = 0; i < H; i++) begin
      exp_s[e+i] = d & ~b;
      exp_r[e+i] = ~d & b;
    end
    fin      = d & ~st;
    x.is_err = (fin != d);
    x.mask   = fin ^ d;
    x.cyc    = e + H + 2;
`ifdef SR_DRV_RETRY_EN
    if (x.is_err) begin
      for (int i = 0; i < H; i++) begin
        exp_s[e+H+2+i] = d & ~fin;
        exp_r[e+H+2+i] = ~d & fin;
      end
      x.cyc = e + 2*H + 4;
    end
`endif
    sb.push_back(x);
    idle_from = x.cyc;
  endtask

  logic [W-1:0] es, er;
  bit           eb;
  exp_t         got;

  always @(negedge clk) begin
    if (armed) begin
      es = exp_s.exists(cyc) ? exp_s[cyc] : '0;
      er = exp_r.exists(cyc) ? exp_r[cyc] : '0;
      eb = (cyc < idle_from);
      chk("s_out", 32'(s_out), 32'(es));
      chk("r_out", 32'(r_out), 32'(er));
      chk("s_and_r_disjoint", 32'(s_out & r_out), 32'd0);
      chk("done_and_err", 32'(done & err), 32'd0);
      chk("busy", 32'(busy), 32'(eb));
      chk("in_ready", 32'(in_ready), 32'(!eb));
      if (done || err) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'({done, err}), 32'd0);
        end else begin
          got = sb.pop_front();
          chk("result_cycle", 32'(cyc), 32'(got.cyc));
          chk("done", 32'(done), 32'(!got.is_err));
          chk("err", 32'(err), 32'(got.is_err));
          chk("err_mask", 32'(err_mask), got.is_err ? 32'(got.mask) : 32'd0);
        end
      end else begin
        chk("err_mask_idle", 32'(err_mask), 32'd0);
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          chk("missing_result", 32'(cyc), 32'(sb[0].cyc));
          void'(sb.pop_front());
        end
      end
    end
    if (!rst) begin
      sb.delete();
      exp_s.delete();
      exp_r.delete();
      idle_from = 0;
      armed     = 1'b1;
    end else if (in_valid && in_ready) begin
      predict(cyc + 1, in_data, bank, stuck);
    end
  end

  // Leaves in_valid high after the accept edge so callers can chain a back-to-back write.
  task automatic send(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int n = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) @(posedge clk);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;

    send(8'hA5);
    wait_idle();
    send(8'h5A);
    send(8'hFF);
    wait_idle();
    send(8'h3C);
    wait_idle();
    send(8'h3C);
    wait_idle();

    stuck = 8'h01;
    @(posedge clk);
    #2;
    send(8'h01);
    wait_idle();
    stuck = 8'h00;
    @(posedge clk);
    #2;

    send(8'hF0);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 0) begin
        wait_idle();
        stuck = ($urandom_range(3) == 0) ? 8'($urandom) : 8'h00;
        @(posedge clk);
        #2;
      end
      send(8'($urandom));
    end
    wait_idle();
    repeat (4) @(posedge clk);
    #2;
    chk("pending_results", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog at cycle %0d: got timeout, expected completion", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sr_excitation_driver.md
Name: sr_excitation_driver

Overview:
Write-side companion to the team's SR-flip-flop register banks. It accepts a target data word over a valid/ready handshake and converts it into per-bit S/R excitation pulses for an external WIDTH-bit SR bank. It reads the bank's Q back to confirm the write, then reports done or error. It never drives the illegal S=R=1 code.

Parameters:
WIDTH, 8, data/bank width in bits
HOLD_CYCLES, 1, cycles S/R excitation stays asserted; legal range >=1

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
in_valid  in  1  target word valid
in_ready  out  1  block can accept; high only in IDLE
in_data  in  WIDTH  target word
q_fb  in  WIDTH  Q readback from SR bank
s_out  out  WIDTH  per-bit set drive to bank
r_out  out  WIDTH  per-bit reset drive to bank
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse: write verified
err  out  1  one-cycle pulse: readback mismatch
err_mask  out  WIDTH  mismatching bits; valid while err=1, else 0

Behaviour:
- Reset (rst=0 at an edge): state IDLE; s_out=r_out=0; done=err=0; err_mask=0; busy=0; in_ready=1. Any in-flight write is dropped with no done/err pulse.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid/q_fb to outputs.
- Handshake: transfer on the edge where in_valid and in_ready are both 1. At that edge the block captures target=in_data and the excitation:
  - S = in_data & ~q_fb
  - R = ~in_data & q_fb
  - Bits already equal to the target get code 00 (hold).
- in_data is ignored outside a transfer. in_valid held high while busy is not accepted until in_ready returns.
- FSM, with the accept edge at cycle k:
  - IDLE: in_ready=1; outputs S/R=0.
  - DRIVE, cycles k+1..k+HOLD_CYCLES: s_out/r_out show the captured excitation.
  - RELEASE, cycle k+HOLD_CYCLES+1: s_out=r_out=0 so the bank holds.
  - CHECK, cycle k+HOLD_CYCLES+2: register the comparison q_fb vs target.
  - Then IDLE at cycle k+HOLD_CYCLES+3: done=1 if the comparison matched, else err=1 with err_mask=q_fb^target. in_ready=1 in this same cycle, so a new accept may happen at its edge.
- Latency is fixed (HOLD_CYCLES+3 from accept to result) even when the excitation is all-zero. There is no shortcut.
- Invariant: (s_out & r_out)==0 in every cycle, including around reset.
- The hold counter is sized for HOLD_CYCLES and does not wrap beyond it.
- done and err are never high together. Both are low except in the result cycle.

Optional Feature:
Macro SR_DRV_RETRY_EN.
- Defined: on the first CHECK mismatch the FSM skips the error report and goes back to DRIVE. It recomputes S/R from the current q_fb against the same target, then repeats RELEASE and CHECK.
  - Result appears at k+2*HOLD_CYCLES+5.
  - A second mismatch raises err. A match on the retry raises done.
  - Exactly one retry per transaction.
- Undefined: no retry; a mismatch reports err directly. Success latency is unchanged in both builds.

Decomposition:
- Package sr_drv_pkg holds:
  - the state enum (IDLE, DRIVE, RELEASE, CHECK);
  - 2-bit excitation code constants SR_HOLD=00, SR_RESET=01, SR_SET=10, SR_ILLEGAL=11;
  - a function returning the SR code for a (q, d) pair.
- Sub-module sr_exc_encode: combinational, WIDTH-wide; takes target and q and produces s/r vectors. It is used at accept and on retry.

Test Plan (WIDTH=8, HOLD_CYCLES=1; bench models the bank as an 8-bit sync SR register clocked on clk):
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> s_out=r_out=0x00, done=err=0, busy=0, in_ready=1, no accept recorded.
- Bank=0x00, write 0xA5 at edge k -> cycle k+1: s_out=0xA5, r_out=0x00. Cycle k+2: both 0x00. Bank reads 0xA5. done=1 at k+4, err=0.
- Bank=0xA5, write 0x5A -> s_out=0x5A, r_out=0xA5 for one cycle. Bank=0x5A, done at k+4. A back-to-back write of 0xFF accepted at edge k+4 gives s_out=0xA5 at k+5.
- Bank=0x3C, write 0x3C -> s_out=r_out=0x00 throughout. done at k+4, same latency.
- Bank bit 0 stuck at 0, write 0x01 -> without retry: err=1, err_mask=0x01 at k+4. With SR_DRV_RETRY_EN: s_out=0x01 again at k+4, err at k+7, done never asserted.
- Reset asserted during DRIVE of write 0xF0 -> s_out=0 the cycle after the reset edge, no done/err pulse, in_ready=1. A whole-run checker confirms (s_out & r_out)==0 on every cycle.
